// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs
//   Shared CPU pipeline types used by the data-memory path.
//   - Word_t          : 32-bit data word.
//   - MemAccessReq_t  : load/store request issued by the execute stage
//                       {ce, we, addr[31:0], wdata[31:0], sel[3:0]}.
//   - DmemState_t     : data-memory responder FSM states.
//   Helper functions classify a request as a real access or a misaligned one.
// ---------------------------------------------------------------------------
package cpu_defs;

  typedef logic [31:0] Word_t;

  typedef struct packed {
    logic       ce;
    logic       we;
    Word_t      addr;
    Word_t      wdata;
    logic [3:0] sel;
  } MemAccessReq_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } DmemState_t;

  localparam logic [3:0] SEL_NONE  = 4'h0;
  localparam logic [3:0] BE_N_IDLE = 4'hF;

  // A request turns into an SRAM access only when enabled, selecting at least
  // one byte and word aligned.
  function automatic logic req_is_valid(input MemAccessReq_t r);
    return r.ce && (r.sel != SEL_NONE) && (r.addr[1:0] == 2'b00);
  endfunction

  // Enabled, selecting bytes, but not word aligned: rejected with a flag.
  function automatic logic req_is_misaligned(input MemAccessReq_t r);
    return r.ce && (r.sel != SEL_NONE) && (r.addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/cpu_dmem_sram_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_dmem_sram_ctrl
//   Data-memory responder: services an EX-stage load/store on an external
//   asynchronous 32-bit SRAM, stalling the pipeline for the duration.
//
//   Parameters
//     ADDR_WIDTH   SRAM word-address width (byte address bits [ADDR_WIDTH+1:2])
//     WAIT_CYCLES  strobe cycles per access, legal 2..15
//
//   Ports
//     clk           system clock, rising edge
//     rst           synchronous active-low reset
//     req           MemAccessReq_t from EX
//     rdata         last read word (updated on completion of a read)
//     stall_req     pipeline hold, combinational from req and state
//     addr_err      misaligned request flag, combinational
//     sram_addr     SRAM word address (registered)
//     sram_data_o   write data to pad (registered)
//     sram_data_oe  pad drive enable, high = drive (registered)
//     sram_data_i   read data from pad
//     sram_ce_n/oe_n/we_n  active-low strobes (registered)
//     sram_be_n     active-low byte enables (registered)
// ---------------------------------------------------------------------------
module cpu_dmem_sram_ctrl
  import cpu_defs::*;
#(
  parameter int ADDR_WIDTH  = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  MemAccessReq_t         req,
  output Word_t                 rdata,
  output logic                  stall_req,
  output logic                  addr_err,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output Word_t                 sram_data_o,
  output logic                  sram_data_oe,
  input  Word_t                 sram_data_i,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [3:0]            sram_be_n
);

  // Counter value of the final ACCESS cycle.
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  DmemState_t            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  lat_we_q, lat_we_d;
  logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
  Word_t                 lat_wdata_q, lat_wdata_d;
  logic [3:0]            lat_be_n_q, lat_be_n_d;
  Word_t                 rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  Word_t                 sram_data_o_q, sram_data_o_d;
  logic                  sram_data_oe_q, sram_data_oe_d;
  logic                  sram_ce_n_q, sram_ce_n_d;
  logic                  sram_oe_n_q, sram_oe_n_d;
  logic                  sram_we_n_q, sram_we_n_d;
  logic [3:0]            sram_be_n_q, sram_be_n_d;

  logic                  in_access_d;

  // Address bits above the SRAM window are deliberately ignored.
  if (ADDR_WIDTH < 30) begin : g_unused_addr
    logic unused_addr_hi;
    assign unused_addr_hi = ^req.addr[31:ADDR_WIDTH+2];
  end

  // Next-state, request latch and read-data capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_be_n_d  = lat_be_n_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_is_valid(req)) begin
          state_d     = ACCESS;
          cnt_d       = 4'd0;
          lat_we_d    = req.we;
          lat_addr_d  = req.addr[ADDR_WIDTH+1:2];
          lat_wdata_d = req.wdata;
          lat_be_n_d  = ~req.sel;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          cnt_d   = 4'd0;
          // The SRAM has had the full strobe window; sample the pad now.
          if (!lat_we_q) begin
            rdata_d = sram_data_i;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Pad values for the coming cycle, derived from the next state so that the
  // registered strobes line up with the ACCESS cycles themselves.
  always_comb begin
    in_access_d    = (state_d == ACCESS);
    sram_addr_d    = lat_addr_d;
    sram_data_o_d  = lat_wdata_d;
    sram_ce_n_d    = 1'b1;
    sram_oe_n_d    = 1'b1;
    sram_we_n_d    = 1'b1;
    sram_data_oe_d = 1'b0;
    sram_be_n_d    = BE_N_IDLE;
    if (in_access_d) begin
      sram_ce_n_d = 1'b0;
      sram_be_n_d = lat_be_n_d;
      if (lat_we_d) begin
        sram_data_oe_d = 1'b1;
        // Final cycle keeps data driven with WE released (hold time).
        sram_we_n_d    = (cnt_d < LAST_CNT) ? 1'b0 : 1'b1;
      end else begin
        sram_oe_n_d = 1'b0;
      end
    end else begin
      sram_ce_n_d = 1'b1;
    end
  end

  // Pipeline hold and misalignment flag.
  always_comb begin
    stall_req = 1'b0;
    addr_err  = 1'b0;
    if (state_q == IDLE) begin
      stall_req = req_is_valid(req);
      addr_err  = req_is_misaligned(req);
    end else if (state_q == ACCESS) begin
      stall_req = 1'b1;
    end else begin
      stall_req = 1'b0;
    end
  end

  // State, latch and pad registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      lat_we_q       <= 1'b0;
      lat_addr_q     <= '0;
      lat_wdata_q    <= 32'h0000_0000;
      lat_be_n_q     <= BE_N_IDLE;
      rdata_q        <= 32'h0000_0000;
      sram_addr_q    <= '0;
      sram_data_o_q  <= 32'h0000_0000;
      sram_data_oe_q <= 1'b0;
      sram_ce_n_q    <= 1'b1;
      sram_oe_n_q    <= 1'b1;
      sram_we_n_q    <= 1'b1;
      sram_be_n_q    <= BE_N_IDLE;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lat_we_q       <= lat_we_d;
      lat_addr_q     <= lat_addr_d;
      lat_wdata_q    <= lat_wdata_d;
      lat_be_n_q     <= lat_be_n_d;
      rdata_q        <= rdata_d;
      sram_addr_q    <= sram_addr_d;
      sram_data_o_q  <= sram_data_o_d;
      sram_data_oe_q <= sram_data_oe_d;
      sram_ce_n_q    <= sram_ce_n_d;
      sram_oe_n_q    <= sram_oe_n_d;
      sram_we_n_q    <= sram_we_n_d;
      sram_be_n_q    <= sram_be_n_d;
    end
  end

  assign rdata        = rdata_q;
  assign sram_addr    = sram_addr_q;
  assign sram_data_o  = sram_data_o_q;
  assign sram_data_oe = sram_data_oe_q;
  assign sram_ce_n    = sram_ce_n_q;
  assign sram_oe_n    = sram_oe_n_q;
  assign sram_we_n    = sram_we_n_q;
  assign sram_be_n    = sram_be_n_q;

endmodule

// File: tb/tb_cpu_dmem_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_dmem_sram_ctrl
//   Two instances (WAIT_CYCLES=2 and 5), each on its own behavioural async
//   SRAM. Expected results come from a reference memory updated with plain
//   byte-merge arithmetic and from cycle masks derived from the access timing.
// ---------------------------------------------------------------------------
module tb_cpu_dmem_sram_ctrl;
  import cpu_defs::*;

  localparam int AW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;

  MemAccessReq_t req2 = '0, req5 = '0;
  Word_t   rdata2, rdata5, din2, din5, dout2, dout5;
  logic    stall2, stall5, aerr2, aerr5, doe2, doe5;
  logic    ce2, ce5, oe2, oe5, we2, we5;
  logic [AW-1:0] sa2, sa5;
  logic [3:0]    be2, be5;

  cpu_dmem_sram_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req2), .rdata(rdata2), .stall_req(stall2),
    .addr_err(aerr2), .sram_addr(sa2), .sram_data_o(dout2), .sram_data_oe(doe2),
    .sram_data_i(din2), .sram_ce_n(ce2), .sram_oe_n(oe2), .sram_we_n(we2),
    .sram_be_n(be2));

  cpu_dmem_sram_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(5)) dut5 (
    .clk(clk), .rst(rst), .req(req5), .rdata(rdata5), .stall_req(stall5),
    .addr_err(aerr5), .sram_addr(sa5), .sram_data_o(dout5), .sram_data_oe(doe5),
    .sram_data_i(din5), .sram_ce_n(ce5), .sram_oe_n(oe5), .sram_we_n(we5),
    .sram_be_n(be5));

  Word_t mem2 [1024];
  Word_t mem5 [1024];
  Word_t ref2 [1024];
  Word_t ref5 [1024];
  logic  mem_init_done = 1'b0;

  int total = 0;
  int bad   = 0;

  function automatic Word_t init_word(input int i);
    if (i == 32'h100) return 32'hDEADBEEF;
    return (Word_t'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [15:0] mask_run(input int first, input int len);
    return ((16'h1 << len) - 16'h1) << first;
  endfunction

  // Asynchronous SRAM models: read is combinational, write merges enabled bytes.
  assign din2 = (!ce2 && !oe2) ? mem2[sa2[9:0]] : 32'h0;
  assign din5 = (!ce5 && !oe5) ? mem5[sa5[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) begin
        mem2[i] <= init_word(i);
        mem5[i] <= init_word(i);
      end
      mem_init_done <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (!ce2 && !we2 && doe2 && !be2[b]) mem2[sa2[9:0]][8*b +: 8] <= dout2[8*b +: 8];
        if (!ce5 && !we5 && doe5 && !be5[b]) mem5[sa5[9:0]][8*b +: 8] <= dout5[8*b +: 8];
      end
    end
  end

  // Drives one request at cycle k=0, random ignored traffic during the access,
  // idle in the DONE cycle; records per-cycle behaviour as bit masks.
  task automatic run_access(input int inst, input logic we, input Word_t addr,
                            input Word_t wdata, input logic [3:0] sel,
                            output logic [15:0] m_stall, output logic [15:0] m_ce,
                            output logic [15:0] m_oe, output logic [15:0] m_we,
                            output logic [15:0] m_doe, output logic [AW-1:0] o_addr,
                            output logic [3:0] o_be, output Word_t o_dout,
                            output logic o_stable, output Word_t o_rdata,
                            output logic o_done_idle);
    int w;
    MemAccessReq_t r;
    logic st, cen, oen, wen, de;
    logic [AW-1:0] sa;
    logic [3:0] be;
    Word_t dq, rd;
    w = (inst == 5) ? 5 : 2;
    m_stall = '0; m_ce = '0; m_oe = '0; m_we = '0; m_doe = '0;
    o_addr = '0; o_be = '0; o_dout = '0; o_stable = 1'b1; o_rdata = '0; o_done_idle = 1'b0;
    for (int k = 0; k <= w + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        r.ce = 1'b1; r.we = we; r.addr = addr; r.wdata = wdata; r.sel = sel;
      end else if (k <= w) begin
        r.ce = 1'($urandom); r.we = 1'($urandom); r.addr = $urandom;
        r.wdata = $urandom; r.sel = 4'($urandom);
      end else begin
        r = '0;
      end
      if (inst == 5) req5 = r; else req2 = r;
      #1;
      if (inst == 5) begin
        st = stall5; cen = ce5; oen = oe5; wen = we5; de = doe5;
        sa = sa5; be = be5; dq = dout5; rd = rdata5;
      end else begin
        st = stall2; cen = ce2; oen = oe2; wen = we2; de = doe2;
        sa = sa2; be = be2; dq = dout2; rd = rdata2;
      end
      m_stall[k] = st; m_ce[k] = !cen; m_oe[k] = !oen; m_we[k] = !wen; m_doe[k] = de;
      if (k == 1) begin
        o_addr = sa; o_be = be; o_dout = dq;
      end else if (k > 1 && k <= w) begin
        if (sa !== o_addr || be !== o_be || (we && dq !== o_dout)) o_stable = 1'b0;
      end
      if (k == w + 1) begin
        o_rdata = rd;
        o_done_idle = cen && oen && wen && (be == 4'hF) && !de;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req2 = '0; req5 = '0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (rdata2 !== 32'h0 || rdata5 !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h/%h expected 0", rdata2, rdata5); end
    total++; if ({stall2, stall5, aerr2, aerr5} !== 4'b0000) begin bad++; $display("FAIL reset_stall: got %b expected 0000", {stall2, stall5, aerr2, aerr5}); end
    total++; if ({ce2, oe2, we2, ce5, oe5, we5} !== 6'b111111) begin bad++; $display("FAIL reset_strobes: got %b expected 111111", {ce2, oe2, we2, ce5, oe5, we5}); end
    total++; if (be2 !== 4'hF || be5 !== 4'hF || doe2 !== 1'b0 || doe5 !== 1'b0) begin bad++; $display("FAIL reset_be_oe: got %h %h %b %b expected f f 0 0", be2, be5, doe2, doe5); end
    total++; if (sa2 !== '0 || dout2 !== 32'h0 || sa5 !== '0 || dout5 !== 32'h0) begin bad++; $display("FAIL reset_addr_data: got %h %h %h %h expected 0", sa2, dout2, sa5, dout5); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    req2.ce = 1'b1; req2.we = 1'b0; req2.addr = 32'h400; req2.wdata = 32'h0; req2.sel = 4'hF;
    #1;
    total++; if (stall2 !== 1'b1) begin bad++; $display("FAIL rst_mid_accept: got %b expected 1", stall2); end
    @(negedge clk);
    req2 = '0;
    rst = 1'b0;
    #1;
    total++; if (ce2 !== 1'b0 || oe2 !== 1'b0) begin bad++; $display("FAIL rst_mid_in_access: got ce_n=%b oe_n=%b expected 0 0", ce2, oe2); end
    @(negedge clk);
    #1;
    total++; if ({ce2, oe2, we2, stall2} !== 4'b1110 || be2 !== 4'hF) begin bad++; $display("FAIL rst_mid_abort: got %b be=%h expected 1110 be=f", {ce2, oe2, we2, stall2}, be2); end
    total++; if (rdata2 !== 32'h0) begin bad++; $display("FAIL rst_mid_rdata: got %h expected 0", rdata2); end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      total++; if (ce2 !== 1'b1 || rdata2 !== 32'h0) begin bad++; $display("FAIL rst_mid_idle%0d: got ce_n=%b rdata=%h expected 1 0", k, ce2, rdata2); end
    end
  endtask

  task automatic test_read();
    logic [15:0] ms, mc, mo, mw, md; logic [AW-1:0] oa; logic [3:0] ob;
    Word_t od, orr; logic ost, oidle;
    run_access(2, 1'b0, 32'h0000_0400, 32'h0, 4'hF, ms, mc, mo, mw, md, oa, ob, od, ost, orr, oidle);
    total++; if (ms !== 16'h0007) begin bad++; $display("FAIL read_stall: got %h expected 0007", ms); end
    total++; if (mc !== 16'h0006 || mo !== 16'h0006 || mw !== 16'h0 || md !== 16'h0) begin bad++; $display("FAIL read_strobes: got ce=%h oe=%h we=%h doe=%h expected 6 6 0 0", mc, mo, mw, md); end
    total++; if (oa !== 20'h00100 || ob !== 4'h0 || ost !== 1'b1) begin bad++; $display("FAIL read_addr: got %h be=%h stable=%b expected 00100 0 1", oa, ob, ost); end
    total++; if (orr !== 32'hDEADBEEF || oidle !== 1'b1) begin bad++; $display("FAIL read_rdata: got %h idle=%b expected deadbeef 1", orr, oidle); end
    repeat (3) @(negedge clk);
    #1;
    total++; if (rdata2 !== 32'hDEADBEEF || stall2 !== 1'b0) begin bad++; $display("FAIL read_hold: got %h stall=%b expected deadbeef 0", rdata2, stall2); end
  endtask

  task automatic test_byte_write();
    logic [15:0] ms, mc, mo, mw, md; logic [AW-1:0] oa; logic [3:0] ob;
    Word_t od, orr, expw; logic ost, oidle;
    expw = (ref2[2] & 32'hFFFF00FF) | 32'h00003300;
    run_access(2, 1'b1, 32'h0000_0008, 32'h11223344, 4'b0010, ms, mc, mo, mw, md, oa, ob, od, ost, orr, oidle);
    ref2[2] = expw;
    total++; if (ms !== 16'h0007 || mc !== 16'h0006) begin bad++; $display("FAIL bwr_stall_ce: got %h %h expected 0007 0006", ms, mc); end
    total++; if (mw !== 16'h0002 || md !== 16'h0006 || mo !== 16'h0) begin bad++; $display("FAIL bwr_we: got we=%h doe=%h oe=%h expected 2 6 0", mw, md, mo); end
    total++; if (ob !== 4'b1101 || od !== 32'h11223344 || oa !== 20'h2 || ost !== 1'b1) begin bad++; $display("FAIL bwr_pads: got be=%b d=%h a=%h st=%b expected 1101 11223344 2 1", ob, od, oa, ost); end
    total++; if (mem2[2] !== expw) begin bad++; $display("FAIL bwr_mem: got %h expected %h", mem2[2], expw); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ms, mc, mo, mw, md, ms2, mc2, mo2, mw2, md2; logic [AW-1:0] oa, oa2; logic [3:0] ob, ob2;
    Word_t od, orr, od2, orr2; logic ost, oidle, ost2, oidle2;
    run_access(2, 1'b1, 32'h0000_0040, 32'hCAFEF00D, 4'hF, ms, mc, mo, mw, md, oa, ob, od, ost, orr, oidle);
    ref2[16] = 32'hCAFEF00D;
    run_access(2, 1'b0, 32'h0000_0040, 32'h0, 4'hF, ms2, mc2, mo2, mw2, md2, oa2, ob2, od2, ost2, orr2, oidle2);
    total++; if (oidle !== 1'b1 || mw !== 16'h0002) begin bad++; $display("FAIL b2b_first: got idle=%b we=%h expected 1 2", oidle, mw); end
    total++; if (ms2 !== 16'h0007 || mo2 !== 16'h0006 || mw2 !== 16'h0) begin bad++; $display("FAIL b2b_second: got stall=%h oe=%h we=%h expected 7 6 0", ms2, mo2, mw2); end
    total++; if (orr2 !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_rdata: got %h expected cafef00d", orr2); end
  endtask

  task automatic test_misaligned();
    Word_t a;
    int ce_low;
    for (int off = 1; off < 4; off++) begin
      a = 32'h400 + 32'(off);
      ce_low = 0;
      @(negedge clk);
      req2.ce = 1'b1; req2.we = 1'(off & 1); req2.addr = a; req2.wdata = $urandom; req2.sel = 4'hF;
      #1;
      total++; if (aerr2 !== 1'b1 || stall2 !== 1'b0) begin bad++; $display("FAIL misalign_flag%0d: got err=%b stall=%b expected 1 0", off, aerr2, stall2); end
      repeat (3) begin
        @(negedge clk);
        #1;
        if (ce2 !== 1'b1) ce_low++;
      end
      total++; if (ce_low != 0) begin bad++; $display("FAIL misalign_noaccess%0d: got %0d ce cycles expected 0", off, ce_low); end
    end
    @(negedge clk);
    req2 = '0;
    #1;
    total++; if (aerr2 !== 1'b0) begin bad++; $display("FAIL misalign_clear: got %b expected 0", aerr2); end
  endtask

  task automatic test_noop();
    int ce_low;
    ce_low = 0;
    @(negedge clk);
    req2.ce = 1'b1; req2.we = 1'b1; req2.addr = 32'h400; req2.wdata = 32'h0; req2.sel = 4'h0;
    #1;
    total++; if (stall2 !== 1'b0 || aerr2 !== 1'b0) begin bad++; $display("FAIL noop_flags: got stall=%b err=%b expected 0 0", stall2, aerr2); end
    repeat (3) begin
      @(negedge clk);
      #1;
      if (ce2 !== 1'b1) ce_low++;
    end
    total++; if (ce_low != 0) begin bad++; $display("FAIL noop_access: got %0d ce cycles expected 0", ce_low); end
    req2.ce = 1'b0; req2.sel = 4'hF; req2.addr = 32'h403;
    #1;
    total++; if (aerr2 !== 1'b0 || stall2 !== 1'b0) begin bad++; $display("FAIL ce0_flags: got err=%b stall=%b expected 0 0", aerr2, stall2); end
    @(negedge clk);
    req2 = '0;
  endtask

  task automatic test_wait5();
    logic [15:0] ms, mc, mo, mw, md; logic [AW-1:0] oa; logic [3:0] ob;
    Word_t od, orr; logic ost, oidle;
    run_access(5, 1'b0, 32'hFFC0_0400, 32'h0, 4'hF, ms, mc, mo, mw, md, oa, ob, od, ost, orr, oidle);
    total++; if (ms !== 16'h003F || $countones(ms) != 6) begin bad++; $display("FAIL w5_stall: got %h expected 003f", ms); end
    total++; if (mo !== 16'h003E || mc !== 16'h003E) begin bad++; $display("FAIL w5_oe: got oe=%h ce=%h expected 003e 003e", mo, mc); end
    total++; if (orr !== ref5[256] || oa !== 20'h00100) begin bad++; $display("FAIL w5_rdata: got %h a=%h expected %h 00100", orr, oa, ref5[256]); end
    run_access(5, 1'b1, 32'h0000_0010, 32'hA5A5_1234, 4'b1001, ms, mc, mo, mw, md, oa, ob, od, ost, orr, oidle);
    ref5[4] = (ref5[4] & 32'h00FFFF00) | 32'hA5000034;
    total++; if (mw !== 16'h001E || md !== 16'h003E || ob !== 4'b0110) begin bad++; $display("FAIL w5_write: got we=%h doe=%h be=%b expected 1e 3e 0110", mw, md, ob); end
    total++; if (mem5[4] !== ref5[4]) begin bad++; $display("FAIL w5_mem: got %h expected %h", mem5[4], ref5[4]); end
  endtask

  task automatic test_random();
    logic [15:0] ms, mc, mo, mw, md; logic [AW-1:0] oa; logic [3:0] ob;
    Word_t od, orr, a, wd, rnd, merged; logic ost, oidle, w;
    logic [9:0] idx; logic [3:0] sel;
    int diffs;
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom); idx = 10'($urandom); rnd = $urandom;
      a = {rnd[31:12], idx, 2'b00};
      wd = $urandom; sel = 4'($urandom_range(1, 15));
      run_access(2, w, a, wd, sel, ms, mc, mo, mw, md, oa, ob, od, ost, orr, oidle);
      total++; if (ms !== mask_run(0, 3) || mc !== mask_run(1, 2) || oidle !== 1'b1) begin bad++; $display("FAIL rnd%0d_timing: got stall=%h ce=%h idle=%b", n, ms, mc, oidle); end
      total++; if (oa !== a[21:2] || ob !== ~sel || ost !== 1'b1) begin bad++; $display("FAIL rnd%0d_addr: got %h be=%b expected %h %b", n, oa, ob, a[21:2], ~sel); end
      if (w) begin
        merged = ref2[idx];
        for (int b = 0; b < 4; b++) if (sel[b]) merged[8*b +: 8] = wd[8*b +: 8];
        ref2[idx] = merged;
        total++; if (mw !== mask_run(1, 1) || od !== wd) begin bad++; $display("FAIL rnd%0d_write: got we=%h d=%h expected 0002 %h", n, mw, od, wd); end
      end else begin
        total++; if (orr !== ref2[idx] || mo !== mask_run(1, 2)) begin bad++; $display("FAIL rnd%0d_read: got %h oe=%h expected %h 0006", n, orr, mo, ref2[idx]); end
      end
    end
    diffs = 0;
    for (int i = 0; i < 1024; i++) if (mem2[i] !== ref2[i]) diffs++;
    total++; if (diffs != 0) begin bad++; $display("FAIL rnd_memory: got %0d differing words expected 0", diffs); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ref2[i] = init_word(i);
      ref5[i] = init_word(i);
    end
    test_reset();
    test_reset_mid_access();
    test_read();
    test_byte_write();
    test_back_to_back();
    test_misaligned();
    test_noop();
    test_wait5();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_dmem_sram_ctrl.md
# cpu_dmem_sram_ctrl

Data-memory responder for the CPU pipeline: accepts the `MemAccessReq_t` load/store request issued by the execute stage and services it on an external asynchronous 32-bit SRAM. It holds the pipeline with `stall_req` for the duration of the access and returns the read word. It sits between the EX/MEM boundary and the board SRAM pins.

## Interface
- `ADDR_WIDTH`, 20, SRAM word-address width; byte address bits `[ADDR_WIDTH+1:2]` are used, upper bits ignored.
- `WAIT_CYCLES`, 2, SRAM strobe cycles per access; legal range 2..15.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset; one clock, reset is synchronous and active-low (`rst`=0 resets on the next rising edge).
- `req`  in  `MemAccessReq_t`  `{ce, we, addr[31:0], wdata[31:0], sel[3:0]}` from EX.
- `rdata`  out  32  read word, valid in DONE and held until the next read completes.
- `stall_req`  out  1  pipeline hold request.
- `addr_err`  out  1  misaligned request flag, combinational.
- `sram_addr`  out  `ADDR_WIDTH`  SRAM word address.
- `sram_data_o`  out  32  write data to pad.
- `sram_data_oe`  out  1  pad output enable, high = drive.
- `sram_data_i`  in  32  read data from pad.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  active-low strobes.
- `sram_be_n`  out  4  active-low byte enables.

## Operation
- A request is valid when `ce`=1, `sel`≠0 and `addr[1:0]`=0.
- `ce`=1 with `sel`=0 is a no-op: no access and no stall.
- Misaligned request (`ce`=1, `sel`≠0, `addr[1:0]`≠0): `addr_err`=1 in the same cycle, no access, `stall_req`=0, FSM stays IDLE.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: on a valid request, latch `we`, word address, `wdata` and `~sel`; `stall_req`=1 combinationally in that cycle; next state ACCESS with counter=0.
  - ACCESS: `sram_ce_n`=0 and `sram_addr`/`sram_be_n` driven from the latched copy.
    - Read: `sram_oe_n`=0 in every ACCESS cycle.
    - Write: `sram_data_oe`=1 for the whole state; `sram_we_n`=0 while counter < `WAIT_CYCLES`-1, then 1 in the final hold cycle.
    - Counter increments each cycle. On counter=`WAIT_CYCLES`-1 go to DONE; a read also captures `sram_data_i` into `rdata` on that edge.
  - DONE: `stall_req`=0 and all strobes inactive; the pipeline advances at the end of this cycle. Next state IDLE unconditionally, so back-to-back requests are processed from IDLE.
- The latched copy is used throughout; `req` changing during ACCESS has no effect.
- Reset values: state IDLE, counter 0, `rdata`=0, `stall_req`=0, `sram_ce_n`/`sram_oe_n`/`sram_we_n`=1, `sram_be_n`=4'hF, `sram_data_oe`=0, `sram_addr`=0, `sram_data_o`=0.
- Reset in ACCESS aborts the access: all strobes inactive from the edge where `rst`=0 is sampled; `rdata` is not updated.

## Timing
- Request first seen in IDLE at cycle T: ACCESS occupies T+1..T+`WAIT_CYCLES`, DONE is T+`WAIT_CYCLES`+1.
- `stall_req` is high for `WAIT_CYCLES`+1 cycles (T..T+`WAIT_CYCLES`).
- Read data is visible on `rdata` from cycle T+`WAIT_CYCLES`+1.
- Minimum request-to-request spacing is `WAIT_CYCLES`+2 cycles.
- All SRAM outputs are registered: no combinational path from `req` to any pad.
- `stall_req` and `addr_err` are combinational from `req` and the state register.

## Structure
- `MemAccessReq_t` stays in `cpu_defs`.
- Add `DmemState_t` (IDLE/ACCESS/DONE) to `cpu_defs`.
- Use the existing `Word_t` for data.
- No sub-module: the counter and FSM are inline, about 150 lines.

## Test plan
- Read, `WAIT_CYCLES`=2: SRAM model word 0x100 = 0xDEADBEEF; `req{ce=1,we=0,addr=0x400,sel=F}` at T → `stall_req` high for T..T+2, `sram_addr`=0x100, `rdata`=0xDEADBEEF at T+3.
- Byte write: `req{ce=1,we=1,addr=0x8,wdata=0x11223344,sel=0010}` → `sram_be_n`=1101, `sram_we_n` low only at T+1, `sram_data_o`=0x11223344; model word 2 changes only in byte 1.
- Back-to-back: read immediately follows write → second request accepted in IDLE at T+4, no overlap of strobes.
- Misaligned: `addr`=0x402, `sel`=F → `addr_err`=1, `stall_req`=0, `sram_ce_n` stays 1.
- Reset mid-access: `rst`=0 at T+1 of a read → strobes inactive next edge, state IDLE, `rdata` keeps the prior value 0.
- `WAIT_CYCLES`=5 read → `stall_req` high exactly 6 cycles, `sram_oe_n` low exactly 5.
